// File: rtl/single_pkg.sv
// rtl/single_pkg.sv - shared types and constants for the single-precision reduction controller
package single_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
  localparam logic [31:0] FP_NEG_ONE = 32'hBF80_0000;

  // Element index width; a one-element vector still needs a 1-bit index.
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/single_add_1clk.sv
// rtl/single_add_1clk.sv - single-precision adder, round-to-nearest-even, one-cycle registered result
module single_add_1clk (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        out_valid,
  output logic [31:0] c
);

  logic [31:0] r_c;
  logic        r_out_valid;
  logic [31:0] w_sum;

  function automatic logic [31:0] fp_add(input logic [31:0] fa, input logic [31:0] fb);
    logic [31:0] x, y;
    logic [7:0]  ex, ey, d;
    logic [26:0] mx, my, sh, mask;
    logic [27:0] s;
    logic [8:0]  e;
    logic [24:0] rm;
    logic        sub, st, rnd, a_nan, b_nan, a_inf, b_inf;
    a_nan = (&fa[30:23]) && (|fa[22:0]);
    b_nan = (&fb[30:23]) && (|fb[22:0]);
    a_inf = (&fa[30:23]) && !(|fa[22:0]);
    b_inf = (&fb[30:23]) && !(|fb[22:0]);
    if (a_nan || b_nan || (a_inf && b_inf && (fa[31] != fb[31])))
      return 32'h7FC0_0000;
    if (a_inf) return fa;
    if (b_inf) return fb;
    if (fa[30:0] < fb[30:0]) begin
      x = fb; y = fa;
    end else begin
      x = fa; y = fb;
    end
    // Denormals use exponent 1 with no hidden bit; three extra LSBs hold guard/round/sticky.
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx = {(x[30:23] != 8'd0), x[22:0], 3'b000};
    my = {(y[30:23] != 8'd0), y[22:0], 3'b000};
    d  = ex - ey;
    if (d >= 8'd27) begin
      sh = 27'd0;
      st = |my;
    end else begin
      mask = (27'd1 << d) - 27'd1;
      sh   = my >> d;
      st   = |(my & mask);
    end
    sh[0] = sh[0] | st;
    sub = x[31] ^ y[31];
    s   = sub ? ({1'b0, mx} - {1'b0, sh}) : ({1'b0, mx} + {1'b0, sh});
    e   = {1'b0, ex};
    if (s == 28'd0)
      return {x[31] & y[31], 31'd0};
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 9'd1;
    end else begin
      for (int i = 0; i < 27; i++) begin
        if (!s[26] && (e > 9'd1)) begin
          s = s << 1;
          e = e - 9'd1;
        end
      end
    end
    rnd = s[2] & (s[1] | s[0] | s[3]);
    rm  = {1'b0, s[26:3]} + {24'd0, rnd};
    if (rm[24]) begin
      rm = rm >> 1;
      e  = e + 9'd1;
    end
    if (e >= 9'd255)
      return {x[31], 8'hFF, 23'd0};
    return {x[31], (rm[23] ? e[7:0] : 8'd0), rm[22:0]};
  endfunction

  assign w_sum = fp_add(a, b);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_c         <= 32'd0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid)
        r_c <= w_sum;
    end
  end

  assign c         = r_c;
  assign out_valid = r_out_valid;

endmodule

// File: rtl/single_sum_v.sv
// rtl/single_sum_v.sv - strict left-to-right FP32 vector reduction over one time-shared adder
module single_sum_v
  import single_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] vector_a [WIDTH],
  output logic        done,
  output logic        busy,
  output logic [31:0] sum
);

  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  state_t        r_state;
  logic          r_done;
  logic          r_busy;
  logic [31:0]   r_acc;
  logic [IW-1:0] r_idx;
  logic [31:0]   r_vec_q [WIDTH];

  logic          w_issue;
  logic          w_out_valid;
  logic [31:0]   w_c;

  assign w_issue = (r_state == ISSUE);

  single_add_1clk u_add (
    .clk       (clk),
    .rstn      (rstn),
    .a         (r_acc),
    .b         (r_vec_q[r_idx]),
    .in_valid  (w_issue),
    .out_valid (w_out_valid),
    .c         (w_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_acc   <= FP_ZERO;
      r_idx   <= '0;
      for (int i = 0; i < WIDTH; i++)
        r_vec_q[i] <= FP_ZERO;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < WIDTH; i++)
              r_vec_q[i] <= vector_a[i];
            r_acc  <= vector_a[0];
            r_idx  <= IW'(1);
            r_busy <= 1'b1;
            if (WIDTH == 1) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          // Results are only trusted here; a stray out_valid elsewhere never touches acc.
          if (w_out_valid) begin
            r_acc <= w_c;
            if (r_idx == LAST) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_state <= ISSUE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign done = r_done;
  assign busy = r_busy;
  assign sum  = r_acc;

endmodule

// File: tb/tb_single_sum_v.sv
// tb/tb_single_sum_v.sv - scoreboard bench for single_sum_v at WIDTH 10, 4, 2 and 1
module tb_single_sum_v;
  import single_pkg::*;

  typedef struct {
    logic [31:0] s;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  start;
  logic [3:0]  done_w;
  logic [3:0]  busy_w;
  logic [31:0] sum_w [4];
  logic [31:0] v10 [10];
  logic [31:0] v4 [4];
  logic [31:0] v2 [2];
  logic [31:0] v1 [1];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q0[$], q1[$], q2[$], q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  single_sum_v #(.WIDTH(10)) u_w10 (.clk(clk), .rstn(rstn), .start(start[0]), .vector_a(v10),
                                   .done(done_w[0]), .busy(busy_w[0]), .sum(sum_w[0]));
  single_sum_v #(.WIDTH(4))  u_w4  (.clk(clk), .rstn(rstn), .start(start[1]), .vector_a(v4),
                                   .done(done_w[1]), .busy(busy_w[1]), .sum(sum_w[1]));
  single_sum_v #(.WIDTH(2))  u_w2  (.clk(clk), .rstn(rstn), .start(start[2]), .vector_a(v2),
                                   .done(done_w[2]), .busy(busy_w[2]), .sum(sum_w[2]));
  single_sum_v #(.WIDTH(1))  u_w1  (.clk(clk), .rstn(rstn), .start(start[3]), .vector_a(v1),
                                   .done(done_w[3]), .busy(busy_w[3]), .sum(sum_w[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic push(input int k, input logic [31:0] s, input int c);
    exp_t e;
    e.s = s;
    e.c = c;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int k);
    exp_t e;
    check($sformatf("sb_expected_done_%0d", k), 32'(qsize(k) != 0), 32'd1);
    if (qsize(k) != 0) begin
      case (k)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        2: e = q2.pop_front();
        default: e = q3.pop_front();
      endcase
      check($sformatf("sum_%0d", k), sum_w[k], e.s);
      check($sformatf("done_cycle_%0d", k), cyc, e.c);
    end
  endtask

  task automatic drain(input int k, input string tag);
    int n = 0;
    while (qsize(k) != 0 && n < 60) begin
      tick();
      n++;
    end
    check(tag, qsize(k), 0);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++)
      if (done_w[k] === 1'b1) sb_pop(k);
  end

  initial begin
    rstn  = 1'b0;
    start = 4'b0;
    for (int i = 0; i < 10; i++) v10[i] = FP_ZERO;
    for (int i = 0; i < 4; i++) v4[i] = FP_ZERO;
    v2[0] = FP_ZERO; v2[1] = FP_ZERO; v1[0] = FP_ZERO;
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_done_%0d", k), 32'(done_w[k]), 32'd0);
      check($sformatf("rst_busy_%0d", k), 32'(busy_w[k]), 32'd0);
      check($sformatf("rst_sum_%0d", k), sum_w[k], FP_ZERO);
    end
    rstn = 1'b1;
    tick();

    // WIDTH=10: latency, busy window, capture isolation, ignored starts, start at done+1.
    for (int i = 0; i < 10; i++) v10[i] = FP_ONE;
    start[0] = 1'b1;
    push(0, 32'h4120_0000, cyc + 19);
    for (int i = 1; i <= 20; i++) begin
      tick();
      start[0] = 1'b0;
      if (i == 1) for (int j = 0; j < 10; j++) v10[j] = 32'h4000_0000;
      check($sformatf("w10_busy_t%0d", i), 32'(busy_w[0]), (i <= 19) ? 32'd1 : 32'd0);
      if (i == 5 || i == 19) begin
        for (int j = 0; j < 10; j++) v10[j] = 32'h4040_0000;
        start[0] = 1'b1;
      end
      if (i == 20) begin
        for (int j = 0; j < 10; j++) v10[j] = 32'h4000_0000;
        start[0] = 1'b1;
        push(0, 32'h41A0_0000, cyc + 19);
      end
    end
    tick();
    start[0] = 1'b0;
    drain(0, "w10_drain");

    // WIDTH=4: running accumulator after each adder result.
    v4[0] = 32'h3F80_0000; v4[1] = 32'h4000_0000; v4[2] = 32'h4040_0000; v4[3] = 32'h4080_0000;
    start[1] = 1'b1;
    push(1, 32'h4120_0000, cyc + 7);
    tick(); start[1] = 1'b0;
    tick(); tick();
    check("w4_acc1", sum_w[1], 32'h4040_0000);
    tick(); tick();
    check("w4_acc2", sum_w[1], 32'h40C0_0000);
    drain(1, "w4_drain");

    // WIDTH=2 cancellation, then WIDTH=1 pass-through.
    v2[0] = FP_ONE; v2[1] = FP_NEG_ONE;
    start[2] = 1'b1;
    push(2, FP_ZERO, cyc + 3);
    tick(); start[2] = 1'b0;
    drain(2, "w2_drain");
    v1[0] = 32'h4049_0FDB;
    start[3] = 1'b1;
    push(3, 32'h4049_0FDB, cyc + 1);
    tick(); start[3] = 1'b0;
    drain(3, "w1_drain");

    // Reset in a WAIT cycle, then a clean run.
    for (int i = 0; i < 10; i++) v10[i] = FP_ONE;
    start[0] = 1'b1;
    tick(); start[0] = 1'b0;
    tick(); tick(); tick();
    check("mid_busy_before_rst", 32'(busy_w[0]), 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_w[0]), 32'd0);
    check("mid_rst_done", 32'(done_w[0]), 32'd0);
    check("mid_rst_sum", sum_w[0], FP_ZERO);
    tick();
    rstn = 1'b1;
    tick();
    start[0] = 1'b1;
    push(0, 32'h4120_0000, cyc + 19);
    tick(); start[0] = 1'b0;
    drain(0, "post_rst_drain");

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
